int_ctrl: RTL and testbench

- Parametrised successor to the fixed 5-source interrupt arbiter.
- Supports N sources and two priority levels (IP register), with nesting tracked by in-service bits.
- Latches a vectored request toward the CPU sequencer and holds it until acknowledged. Auto-clears source flags on acknowledge and releases the in-service level on RETI.
- Sits between the SFR block (IE/IP/TCON/SCON flags) and the core control FSM.

---
 rtl/int_pkg.sv | 21 ++
 rtl/int_ctrl_if.sv | 33 +++
 rtl/int_prio_enc.sv | 27 ++
 rtl/int_ctrl.sv | 126 ++++++++++++
 tb/tb_int_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// 8051 source index constants and default vector layout.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } int_state_e;

  // Classic 8051 source ordering (index 0 = highest natural priority)
  localparam int unsigned SRC_IE0 = 0;
  localparam int unsigned SRC_TF0 = 1;
  localparam int unsigned SRC_IE1 = 2;
  localparam int unsigned SRC_TF1 = 3;
  localparam int unsigned SRC_SER = 4;

  localparam int unsigned VEC_BASE_DEF   = 32'h0003;
  localparam int unsigned VEC_STRIDE_DEF = 8;

endpackage

// File: rtl/int_ctrl_if.sv
// Interrupt controller bus: SFR-side enables/flags, CPU handshake and the
// vectored request back to the core.
//   slave  : the controller (int_ctrl)
//   master : the SFR block / core sequencer driving it
interface int_ctrl_if #(
  parameter int unsigned N_SRC = 5,
  parameter int unsigned VEC_W = 16
);
  localparam int unsigned ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic             ea;
  logic [N_SRC-1:0] ie;
  logic [N_SRC-1:0] ip;
  logic [N_SRC-1:0] flag;
  logic [N_SRC-1:0] auto_clr;
  logic             irq_ack;
  logic             reti;
  logic             irq_req;
  logic [ID_W-1:0]  irq_id;
  logic [VEC_W-1:0] irq_vec;
  logic [N_SRC-1:0] clr_flag;
  logic [1:0]       in_svc;

  modport master (
    output ea, ie, ip, flag, auto_clr, irq_ack, reti,
    input  irq_req, irq_id, irq_vec, clr_flag, in_svc
  );

  modport slave (
    input  ea, ie, ip, flag, auto_clr, irq_ack, reti,
    output irq_req, irq_id, irq_vec, clr_flag, in_svc
  );
endinterface

// File: rtl/int_prio_enc.sv
// Find-first-set: reports whether any request bit is set and the lowest
// set index.
//   i_req   : request mask
//   o_valid : at least one bit set
//   o_idx   : index of the lowest set bit (0 when none)
module int_prio_enc #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [WIDTH-1:0] i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Scan downward so the lowest index is the last (winning) assignment
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Two-level vectored interrupt controller for N sources.
// Arbitrates eligible sources (high level first, then lowest index), latches
// the winning id/vector toward the CPU until acknowledged, pulses the source
// flag clear on ack and tracks in-service levels for nesting/RETI.
//   clk, rst : core clock, async active-high reset
//   bus      : int_ctrl_if slave (enables, flags, ack/reti in; request out)
// Build option: INT_CTRL_REARB_EN re-runs arbitration while a request waits.
module int_ctrl
  import int_pkg::*;
#(
  parameter int unsigned N_SRC      = 5,
  parameter int unsigned VEC_W      = 16,
  parameter int unsigned VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  int_ctrl_if.slave  bus
);

  localparam int unsigned ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] w_elig;
  logic             w_hi_vld, w_lo_vld, w_any;
  logic [ID_W-1:0]  w_hi_idx, w_lo_idx, w_win_id;
  logic [VEC_W-1:0] w_win_vec;

  int_state_e       r_state, w_state_nxt;
  logic [ID_W-1:0]  r_id, w_id_nxt;
  logic [VEC_W-1:0] r_vec, w_vec_nxt;
  logic [N_SRC-1:0] r_clr, w_clr_nxt;
  logic [1:0]       r_svc, w_svc_nxt;

  // Low level needs nothing in service; high level only needs no high nesting
  always_comb begin
    for (int i = 0; i < int'(N_SRC); i++) begin
      w_elig[i] = bus.ea & bus.ie[i] & bus.flag[i] & (bus.ip[i] ? ~r_svc[1] : ~|r_svc);
    end
  end

  int_prio_enc #(.WIDTH(N_SRC), .IDX_W(ID_W)) u_enc_hi (
    .i_req   (w_elig & bus.ip),
    .o_valid (w_hi_vld),
    .o_idx   (w_hi_idx)
  );

  int_prio_enc #(.WIDTH(N_SRC), .IDX_W(ID_W)) u_enc_lo (
    .i_req   (w_elig & ~bus.ip),
    .o_valid (w_lo_vld),
    .o_idx   (w_lo_idx)
  );

  assign w_any     = w_hi_vld | w_lo_vld;
  assign w_win_id  = w_hi_vld ? w_hi_idx : w_lo_idx;
  // Modular arithmetic: truncating each term gives the truncated full sum
  assign w_win_vec = VEC_W'(VEC_BASE) + VEC_W'(w_win_id) * VEC_W'(VEC_STRIDE);

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_vec_nxt   = r_vec;
    w_clr_nxt   = '0;
    w_svc_nxt   = r_svc;

    // RETI releases the innermost level before any same-cycle ack sets one
    if (bus.reti) begin
      if (r_svc[1]) w_svc_nxt[1] = 1'b0;
      else          w_svc_nxt[0] = 1'b0;
    end

    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = REQ;
          w_id_nxt    = w_win_id;
          w_vec_nxt   = w_win_vec;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          w_state_nxt                = HOLD;
          w_svc_nxt[bus.ip[r_id]]    = 1'b1;
          w_clr_nxt[r_id]            = bus.auto_clr[r_id];
        end
`ifdef INT_CTRL_REARB_EN
        else if (w_any) begin
          w_id_nxt  = w_win_id;
          w_vec_nxt = w_win_vec;
        end else begin
          w_state_nxt = IDLE;
        end
`else
        else if (!w_elig[r_id]) begin
          w_state_nxt = IDLE;
        end
`endif
      end
      // Gives the flag clear a cycle to land before arbitrating again
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_vec   <= '0;
      r_clr   <= '0;
      r_svc   <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
      r_vec   <= w_vec_nxt;
      r_clr   <= w_clr_nxt;
      r_svc   <= w_svc_nxt;
    end
  end

  assign bus.irq_req  = (r_state == REQ);
  assign bus.irq_id   = r_id;
  assign bus.irq_vec  = r_vec;
  assign bus.clr_flag = r_clr;
  assign bus.in_svc   = r_svc;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the controller.
module tb_int_ctrl;

  logic clk;
  logic rst;

  int_ctrl_if #(.N_SRC(5), .VEC_W(16)) bus ();

  int_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  bit         m_req;
  bit         m_hold;
  int         m_id;
  logic [4:0] m_clr;
  logic [1:0] m_svc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_vec(input int id);
    return (3 + id * 8) & 32'hFFFF;
  endfunction

  // High-level sources first, lowest index within a level; -1 when none
  function automatic int pick(input logic [4:0] elig, input logic [4:0] ip);
    for (int i = 0; i < 5; i++) if (elig[i] && ip[i]) return i;
    for (int i = 0; i < 5; i++) if (elig[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_req = 0; m_hold = 0; m_id = 0; m_clr = '0; m_svc = 2'b00;
  endtask

  task automatic model_step();
    logic [4:0] elig;
    logic [1:0] svc_n;
    logic [4:0] clr_n;
    int w;
    for (int i = 0; i < 5; i++) begin
      if (bus.ip[i]) elig[i] = bus.ea && bus.ie[i] && bus.flag[i] && !m_svc[1];
      else           elig[i] = bus.ea && bus.ie[i] && bus.flag[i] && (m_svc == 2'b00);
    end
    svc_n = m_svc;
    if (bus.reti) begin
      if (svc_n[1]) svc_n[1] = 1'b0;
      else          svc_n[0] = 1'b0;
    end
    clr_n = '0;
    w = pick(elig, bus.ip);
    if (m_hold) begin
      m_hold = 0;
    end else if (!m_req) begin
      if (w >= 0) begin m_req = 1; m_id = w; end
    end else if (bus.irq_ack) begin
      svc_n[bus.ip[m_id]] = 1'b1;
      if (bus.auto_clr[m_id]) clr_n[m_id] = 1'b1;
      m_req = 0; m_hold = 1;
    end else begin
`ifdef INT_CTRL_REARB_EN
      if (w >= 0) m_id = w;
      else        m_req = 0;
`else
      if (!elig[m_id]) m_req = 0;
`endif
    end
    m_svc = svc_n;
    m_clr = clr_n;
  endtask

  task automatic check_all();
    chk("irq_req", 32'(bus.irq_req), 32'(m_req));
    if (m_req) begin
      chk("irq_id", 32'(bus.irq_id), 32'(m_id));
      chk("irq_vec", 32'(bus.irq_vec), 32'(exp_vec(m_id)));
    end
    chk("clr_flag", 32'(bus.clr_flag), 32'(m_clr));
    chk("in_svc", 32'(bus.in_svc), 32'(m_svc));
  endtask

  // One clock: model advances on the same inputs the DUT samples
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    bus.flag = bus.flag & ~m_clr;  // SFR honours the clear pulse
  endtask

  task automatic run_until_req(input int budget);
    for (int k = 0; k < budget && !m_req; k++) tick();
    chk("req_wait", 32'(bus.irq_req), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.ea = 0; bus.ie = '0; bus.ip = '0; bus.flag = '0; bus.auto_clr = '0;
    bus.irq_ack = 0; bus.reti = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.irq_req), 0);
    chk("rst_id", 32'(bus.irq_id), 0);
    chk("rst_vec", 32'(bus.irq_vec), 0);
    chk("rst_clr", 32'(bus.clr_flag), 0);
    chk("rst_svc", 32'(bus.in_svc), 0);
    rst = 1'b0;

    // Basic low-level request, ack with auto-clear
    bus.ea = 1; bus.ie = 5'h1F; bus.ip = 5'h00; bus.auto_clr = 5'h1F; bus.flag = 5'b00110;
    tick();
    chk("t1_req", 32'(bus.irq_req), 1);
    chk("t1_vec", 32'(bus.irq_vec), 32'h000B);
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    chk("t1_clr", 32'(bus.clr_flag), 32'h02);
    chk("t1_svc", 32'(bus.in_svc), 2'b01);
    tick();
    chk("t1_clr_one", 32'(bus.clr_flag), 0);

    // Nested high-level request over low in service
    bus.ip = 5'b01000; bus.flag = bus.flag | 5'b01000;
    run_until_req(5);
    chk("t2_id", 32'(bus.irq_id), 3);
    chk("t2_vec", 32'(bus.irq_vec), 32'h001B);
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    chk("t2_svc11", 32'(bus.in_svc), 2'b11);
    bus.reti = 1; tick();
    chk("t2_reti1", 32'(bus.in_svc), 2'b01);
    tick(); bus.reti = 0;
    chk("t2_reti0", 32'(bus.in_svc), 2'b00);
    bus.flag = '0;
    repeat (3) tick();

    // High level beats index 0
    bus.ip = 5'b10000; bus.flag = 5'b10001;
    run_until_req(5);
    chk("t3_id", 32'(bus.irq_id), 4);
    chk("t3_vec", 32'(bus.irq_vec), 32'h0023);

    // Withdraw by disabling the latched source
    bus.ie[4] = 1'b0;
    tick();
    chk("t4_req", 32'(bus.irq_req), 0);
    chk("t4_clr", 32'(bus.clr_flag), 0);
    chk("t4_svc", 32'(bus.in_svc), 0);
    bus.flag = '0; bus.ie = 5'h1F;
    repeat (3) tick();

    // Flag held (no auto-clear): re-request two cycles after ack once level frees
    bus.ip = '0; bus.auto_clr = '0; bus.flag = 5'b00100;
    run_until_req(5);
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    chk("t5_ack_req", 32'(bus.irq_req), 0);
    chk("t5_ack_clr", 32'(bus.clr_flag), 0);
    bus.reti = 1; tick(); bus.reti = 0;
    chk("t5_hold_req", 32'(bus.irq_req), 0);
    tick();
    chk("t5_rereq", 32'(bus.irq_req), 1);
    chk("t5_reid", 32'(bus.irq_id), 2);

    // Async reset mid-REQ, no clock edge involved
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_req", 32'(bus.irq_req), 0);
    chk("t6_id", 32'(bus.irq_id), 0);
    chk("t6_vec", 32'(bus.irq_vec), 0);
    chk("t6_clr", 32'(bus.clr_flag), 0);
    chk("t6_svc", 32'(bus.in_svc), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.flag = '0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bus.ea = ($urandom_range(15) != 0);
      if ($urandom_range(7) == 0)  bus.ie = 5'($urandom);
      if ($urandom_range(15) == 0) bus.ip = 5'($urandom);
      if ($urandom_range(15) == 0) bus.auto_clr = 5'($urandom);
      bus.flag = bus.flag | (5'($urandom) & 5'($urandom) & 5'($urandom));
      if ($urandom_range(19) == 0) bus.flag = bus.flag & 5'($urandom);
      bus.irq_ack = m_req ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      bus.reti = ($urandom_range(9) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
